// File: rtl/conv_kernel_pos_seq.sv
// Raster-scan kernel border-flag sequencer with SOF/EOL/EOF framing over valid/ready.
// Optional statistics outputs are built when CONV_KERNEL_POS_SEQ_STATS_EN is defined.
package conv_pkg;
  typedef struct packed {
    logic n1;
    logic n2;
    logic s1;
    logic s2;
    logic w1;
    logic w2;
    logic e1;
    logic e2;
  } kernel_pos_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } seq_state_t;
endpackage

module conv_kernel_pos_seq #(
  parameter int W_W = 16,
  parameter int H_W = 16
) (
  input  logic                    clk,
  input  logic                    arst_n,
  input  logic                    start_i,
  input  logic                    abort_i,
  input  logic [W_W-1:0]          cfg_width_i,
  input  logic [H_W-1:0]          cfg_height_i,
  output logic                    pos_vld_o,
  input  logic                    pos_rdy_i,
  output conv_pkg::kernel_pos_t   kernel_pos_o,
  output logic                    sof_o,
  output logic                    eol_o,
  output logic                    eof_o,
  output logic                    busy_o,
  output logic                    cfg_err_o,
`ifdef CONV_KERNEL_POS_SEQ_STATS_EN
  output logic [31:0]             stall_cnt_o,
  output logic [15:0]             frame_cnt_o,
`endif
  output conv_pkg::seq_state_t    state_o
);
  import conv_pkg::*;

  // Handshake: a token moves when pos_vld_o & pos_rdy_i; while valid is high and
  // ready is low every output holds; valid only drops after a transfer, abort or reset.

  seq_state_t     state;
  logic [W_W-1:0] width_q;
  logic [H_W-1:0] height_q;
  logic [H_W-1:0] row;
  logic [W_W-1:0] col;

  // H-2 / W-2 comparisons are gated by the size so small frames cannot alias via underflow.
  function automatic kernel_pos_t calc_pos(input logic [H_W-1:0] r, input logic [W_W-1:0] c,
                                           input logic [W_W-1:0] w, input logic [H_W-1:0] h);
    kernel_pos_t p;
    p    = '0;
    p.n2 = (r == '0);
    p.n1 = (r == H_W'(1));
    p.s2 = (r == h - H_W'(1));
    p.s1 = (h >= H_W'(2)) && (r == h - H_W'(2));
    p.w2 = (c == '0);
    p.w1 = (c == W_W'(1));
    p.e2 = (c == w - W_W'(1));
    p.e1 = (w >= W_W'(2)) && (c == w - W_W'(2));
    return p;
  endfunction

  logic           xfer;
  logic           cfg_zero;
  logic           last_col;
  logic [W_W-1:0] next_col;
  logic [H_W-1:0] next_row;
  logic           next_eol;
  logic           next_eof;
  kernel_pos_t    next_pos;
  kernel_pos_t    start_pos;
  logic           start_eol;
  logic           start_eof;

  always_comb begin
    xfer      = pos_vld_o & pos_rdy_i;
    cfg_zero  = (cfg_width_i == '0) || (cfg_height_i == '0);
    last_col  = (col == width_q - W_W'(1));
    next_col  = last_col ? '0 : col + W_W'(1);
    next_row  = last_col ? row + H_W'(1) : row;
    next_eol  = (next_col == width_q - W_W'(1));
    next_eof  = next_eol && (next_row == height_q - H_W'(1));
    next_pos  = calc_pos(next_row, next_col, width_q, height_q);
    start_pos = calc_pos('0, '0, cfg_width_i, cfg_height_i);
    start_eol = (cfg_width_i == W_W'(1));
    start_eof = start_eol && (cfg_height_i == H_W'(1));
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state        <= ST_IDLE;
      width_q      <= '0;
      height_q     <= '0;
      row          <= '0;
      col          <= '0;
      pos_vld_o    <= 1'b0;
      kernel_pos_o <= '0;
      sof_o        <= 1'b0;
      eol_o        <= 1'b0;
      eof_o        <= 1'b0;
      cfg_err_o    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            if (cfg_zero) begin
              cfg_err_o <= 1'b1;
            end else begin
              cfg_err_o    <= 1'b0;
              width_q      <= cfg_width_i;
              height_q     <= cfg_height_i;
              row          <= '0;
              col          <= '0;
              pos_vld_o    <= 1'b1;
              kernel_pos_o <= start_pos;
              sof_o        <= 1'b1;
              eol_o        <= start_eol;
              eof_o        <= start_eof;
              state        <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          // Abort wins over a transfer in the same cycle: the presented token is dropped.
          if (abort_i || (xfer && eof_o)) begin
            row          <= '0;
            col          <= '0;
            pos_vld_o    <= 1'b0;
            kernel_pos_o <= '0;
            sof_o        <= 1'b0;
            eol_o        <= 1'b0;
            eof_o        <= 1'b0;
            state        <= abort_i ? ST_IDLE : ST_DRAIN;
          end else if (xfer) begin
            row          <= next_row;
            col          <= next_col;
            kernel_pos_o <= next_pos;
            sof_o        <= 1'b0;
            eol_o        <= next_eol;
            eof_o        <= next_eof;
          end
        end
        ST_DRAIN: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign busy_o  = (state != ST_IDLE);
  assign state_o = state;

`ifdef CONV_KERNEL_POS_SEQ_STATS_EN
  logic accept_start;
  logic eof_accept;

  assign accept_start = (state == ST_IDLE) && start_i && !cfg_zero;
  assign eof_accept   = (state == ST_RUN) && xfer && eof_o && !abort_i;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stall_cnt_o <= '0;
      frame_cnt_o <= '0;
    end else if (accept_start) begin
      stall_cnt_o <= '0;
      frame_cnt_o <= '0;
    end else begin
      if (pos_vld_o && !pos_rdy_i && !(&stall_cnt_o)) stall_cnt_o <= stall_cnt_o + 32'd1;
      if (eof_accept) frame_cnt_o <= frame_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_conv_kernel_pos_seq.sv
// Scoreboard bench for conv_kernel_pos_seq: per-frame expected tokens are queued at start,
// a negedge monitor pops and compares on every accepted token.
module tb_conv_kernel_pos_seq;
  import conv_pkg::*;

  localparam int W_W = 16;
  localparam int H_W = 16;

  logic           clk = 1'b0;
  logic           arst_n = 1'b0;
  logic           start_i = 1'b0;
  logic           abort_i = 1'b0;
  logic           pos_rdy_i = 1'b0;
  logic [W_W-1:0] cfg_width_i = '0;
  logic [H_W-1:0] cfg_height_i = '0;
  logic           pos_vld_o;
  kernel_pos_t    kernel_pos_o;
  logic           sof_o, eol_o, eof_o, busy_o, cfg_err_o;
  seq_state_t     state_o;
`ifdef CONV_KERNEL_POS_SEQ_STATS_EN
  logic [31:0]    stall_cnt_o;
  logic [15:0]    frame_cnt_o;
`endif

  conv_kernel_pos_seq #(.W_W(W_W), .H_W(H_W)) dut (
    .clk(clk), .arst_n(arst_n), .start_i(start_i), .abort_i(abort_i),
    .cfg_width_i(cfg_width_i), .cfg_height_i(cfg_height_i),
    .pos_vld_o(pos_vld_o), .pos_rdy_i(pos_rdy_i), .kernel_pos_o(kernel_pos_o),
    .sof_o(sof_o), .eol_o(eol_o), .eof_o(eof_o), .busy_o(busy_o), .cfg_err_o(cfg_err_o),
`ifdef CONV_KERNEL_POS_SEQ_STATS_EN
    .stall_cnt_o(stall_cnt_o), .frame_cnt_o(frame_cnt_o),
`endif
    .state_o(state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          tests = 0;
  int          fails = 0;
  int          rdy_mode = 0;
  int          xfer_cnt = 0;
  int          stall_meas = 0;
  int          sof_cyc = -1;
  int          eof_cyc = -1;
  logic [10:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: the frame's tokens in raster order, flags from plain integer rules.
  task automatic push_frame(input int w, input int h, input int limit);
    int n;
    n = 0;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        if (n < limit) begin
          exp_q.push_back({r == 1, r == 0, r == h - 2, r == h - 1,
                           c == 1, c == 0, c == w - 2, c == w - 1,
                           (r == 0) && (c == 0), c == w - 1, (c == w - 1) && (r == h - 1)});
        end
        n++;
      end
    end
  endtask

  // ready driver
  initial begin
    forever begin
      @(posedge clk);
      #1;
      pos_rdy_i = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  // monitor
  logic        prev_stall = 1'b0;
  logic [11:0] prev_out = '0;
  initial begin
    logic [10:0] got;
    forever begin
      @(negedge clk);
      if (!arst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) check("stall_hold", {pos_vld_o, kernel_pos_o, sof_o, eol_o, eof_o}, prev_out);
        if (pos_vld_o && !pos_rdy_i) stall_meas++;
        if (pos_vld_o && pos_rdy_i && !abort_i) begin
          xfer_cnt++;
          got = {kernel_pos_o, sof_o, eol_o, eof_o};
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL extra_token: got %0h expected none (cycle %0d)", got, cyc);
          end else begin
            check("token", got, exp_q.pop_front());
          end
          if (sof_o) sof_cyc = cyc;
          if (eof_o) eof_cyc = cyc;
        end
        prev_stall = pos_vld_o && !pos_rdy_i && !abort_i;
        prev_out   = {pos_vld_o, kernel_pos_o, sof_o, eol_o, eof_o};
      end
    end
  end

  // driver tasks
  task automatic start_frame(input int w, input int h);
    @(posedge clk);
    #1;
    cfg_width_i  = W_W'(w);
    cfg_height_i = H_W'(h);
    start_i      = 1'b1;
    stall_meas   = 0;
    @(posedge clk);
    #1;
    start_i      = 1'b0;
    cfg_width_i  = W_W'($urandom_range(0, 9));
    cfg_height_i = H_W'($urandom_range(0, 9));
    if (w != 0 && h != 0) begin
      check("first_valid", pos_vld_o, 1'b1);
      check("first_sof", sof_o, 1'b1);
    end
  endtask

  task automatic finish_frame(input int w, input int h, input int mode);
    int n;
    n = 0;
    while (busy_o && n < 5000) begin
      @(negedge clk);
      n++;
      if (eof_cyc >= 0 && cyc == eof_cyc + 1) begin
        check("drain_vld", pos_vld_o, 1'b0);
        check("drain_busy", busy_o, 1'b1);
      end
    end
    if (n >= 5000) begin
      tests++;
      fails++;
      $display("FAIL frame_timeout: got busy after %0d cycles expected idle", n);
    end
    check("busy_fall_lat", 32'(cyc - eof_cyc), 32'd2);
    check("queue_empty", exp_q.size(), 32'd0);
    if (mode == 0) check("frame_cycles", 32'(eof_cyc - sof_cyc), 32'(w * h - 1));
`ifdef CONV_KERNEL_POS_SEQ_STATS_EN
    check("stall_cnt", stall_cnt_o, 32'(stall_meas));
    check("frame_cnt", frame_cnt_o, 32'd1);
`endif
  endtask

  task automatic run_frame(input int w, input int h, input int mode);
    rdy_mode = mode;
    eof_cyc  = -1;
    push_frame(w, h, w * h);
    start_frame(w, h);
    finish_frame(w, h, mode);
  endtask

  task automatic wait_xfers(input int target);
    int n;
    n = 0;
    while (xfer_cnt != target && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 2000) begin
      tests++;
      fails++;
      $display("FAIL xfer_timeout: got %0d transfers expected %0d", xfer_cnt, target);
    end
  endtask

  initial begin
    int base;
    #1;
    check("rst_vld", pos_vld_o, 1'b0);
    check("rst_flags", {kernel_pos_o, sof_o, eol_o, eof_o}, 11'd0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_err", cfg_err_o, 1'b0);
    check("rst_state", 32'(state_o), 32'(ST_IDLE));
    #20 arst_n = 1'b1;

    run_frame(5, 4, 0);
    run_frame(1, 1, 0);
    run_frame(3, 3, 1);

    // zero geometry sets the sticky error and produces nothing
    rdy_mode = 0;
    start_frame(0, 7);
    check("err_set", cfg_err_o, 1'b1);
    repeat (3) @(negedge clk);
    check("err_no_vld", pos_vld_o, 1'b0);
    check("err_no_busy", busy_o, 1'b0);
    run_frame(2, 2, 0);
    check("err_cleared", cfg_err_o, 1'b0);

    // start while busy is ignored, including its zero geometry
    rdy_mode = 1;
    eof_cyc  = -1;
    push_frame(4, 3, 12);
    start_frame(4, 3);
    @(posedge clk);
    #1;
    cfg_width_i = '0;
    start_i     = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    check("busy_start_err", cfg_err_o, 1'b0);
    finish_frame(4, 3, 1);

    // abort on the 6th token
    rdy_mode = 0;
    base     = xfer_cnt;
    push_frame(4, 4, 5);
    start_frame(4, 4);
    wait_xfers(base + 5);
    abort_i = 1'b1;
    @(posedge clk);
    #1;
    abort_i = 1'b0;
    check("abort_vld", pos_vld_o, 1'b0);
    check("abort_busy", busy_o, 1'b0);
    check("abort_state", 32'(state_o), 32'(ST_IDLE));
    check("abort_flags", {kernel_pos_o, sof_o, eol_o, eof_o}, 11'd0);
    check("abort_xfers", 32'(xfer_cnt - base), 32'd5);
    check("abort_queue", exp_q.size(), 32'd0);
`ifdef CONV_KERNEL_POS_SEQ_STATS_EN
    check("abort_frame_cnt", frame_cnt_o, 32'd0);
`endif
    run_frame(4, 4, 0);

    // asynchronous reset at token 30
    base = xfer_cnt;
    push_frame(8, 8, 30);
    start_frame(8, 8);
    wait_xfers(base + 30);
    #2;
    arst_n = 1'b0;
    #1;
    check("arst_vld", pos_vld_o, 1'b0);
    check("arst_flags", {kernel_pos_o, sof_o, eol_o, eof_o}, 11'd0);
    check("arst_busy", busy_o, 1'b0);
    check("arst_state", 32'(state_o), 32'(ST_IDLE));
    check("arst_queue", exp_q.size(), 32'd0);
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    run_frame(3, 2, 0);

    for (int i = 0; i < 4; i++) run_frame($urandom_range(1, 6), $urandom_range(1, 5), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end
endmodule
